// File: rtl/pipe_pkg.sv
// Shared opcode constants, PC command encodings and sequencer state for pipe_ctrl.
package pipe_pkg;

   // Opcodes recognised by the hazard/control sequencer
   localparam logic [5:0] RTYPE = 6'd0;
   localparam logic [5:0] LOAD  = 6'd16;
   localparam logic [5:0] STORE = 6'd24;
   localparam logic [5:0] BR_EQ = 6'd32;
   localparam logic [5:0] BR_NE = 6'd33;
   localparam logic [5:0] BR_GT = 6'd34;
   localparam logic [5:0] BR_LE = 6'd35;
   localparam logic [5:0] J     = 6'd40;
   localparam logic [5:0] JAL   = 6'd41;
   localparam logic [5:0] JR    = 6'd42;
   localparam logic [5:0] HALT  = 6'd63;

   // PC command encodings driven on stop_d
   localparam logic [1:0] STOP_RUN  = 2'b00;
   localparam logic [1:0] STOP_JMP  = 2'b01;
   localparam logic [1:0] STOP_HOLD = 2'b10;
   localparam logic [1:0] STOP_BR   = 2'b11;

   // Sequencer states; ST_ prefix keeps them apart from the HALT opcode
   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_STALL   = 2'd1,
      ST_BR_WAIT = 2'd2,
      ST_HALT    = 2'd3
   } state_e;

   // Conditional branches and JR resolve over two cycles
   function automatic logic is_branch(input logic [5:0] op);
      return ((op >= BR_EQ) && (op <= BR_LE)) || (op == JR);
   endfunction

   // Absolute jumps resolve in a single cycle
   function automatic logic is_jump(input logic [5:0] op);
      return (op == J) || (op == JAL);
   endfunction

   // Instructions that read rt as a source operand
   function automatic logic uses_rt(input logic [5:0] op);
      return (op == RTYPE) || (op == STORE) || ((op >= BR_EQ) && (op <= BR_LE));
   endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// Load-use hazard detector: a load in execute writes a register read by decode.
// Purely combinational so the forwarding unit can reuse it unchanged.
module hazard_det
   import pipe_pkg::*;
(
   input  logic [5:0] op_e,
   input  logic       wr_e,
   input  logic [4:0] rd_e,
   input  logic [5:0] op_d,
   input  logic [4:0] rs_d,
   input  logic [4:0] rt_d,
   output logic       hz
);

   logic load_wr_s;
   logic rs_match_s;
   logic rt_match_s;

   // r0 is hard-wired to zero, so a load targeting it never creates a dependency
   assign load_wr_s  = (op_e == LOAD) && wr_e && (rd_e != 5'd0);
   assign rs_match_s = (rd_e == rs_d);
   assign rt_match_s = uses_rt(op_d) && (rd_e == rt_d);
   assign hz         = load_wr_s && (rs_match_s || rt_match_s);

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and control-flow sequencer for the 5-stage pipeline: issues PC commands
// and IF/ID, ID/EX hold/flush/bubble controls; counts PC-hold cycles.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rstd,
   input  logic [5:0]       op_d,
   input  logic [4:0]       rs_d,
   input  logic [4:0]       rt_d,
   input  logic [5:0]       op_e,
   input  logic [4:0]       rd_e,
   input  logic             wr_e,
   output logic [1:0]       stop_d,
   output logic             stall_fd,
   output logic             flush_fd,
   output logic             bubble_de,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt
);

   // Remaining stall cycles after the one spent in RUN detecting the hazard
   localparam logic [1:0] LAT_M1 = 2'(LOAD_LAT - 1);

   state_e           state_r;
   state_e           state_nxt_s;
   logic [1:0]       cnt_r;
   logic [1:0]       cnt_nxt_s;
   logic             halted_r;
   logic [CNT_W-1:0] stall_cnt_r;
   logic             hz_s;
   logic [1:0]       stop_s;
   logic             stall_fd_s;
   logic             flush_fd_s;
   logic             bubble_de_s;

   hazard_det u_hazard_det (
      .op_e (op_e),
      .wr_e (wr_e),
      .rd_e (rd_e),
      .op_d (op_d),
      .rs_d (rs_d),
      .rt_d (rt_d),
      .hz   (hz_s)
   );

   // Next-state and same-cycle control outputs; in RUN the hazard outranks control flow
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      stop_s      = STOP_RUN;
      stall_fd_s  = 1'b0;
      flush_fd_s  = 1'b0;
      bubble_de_s = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (hz_s) begin
               stop_s      = STOP_HOLD;
               stall_fd_s  = 1'b1;
               bubble_de_s = 1'b1;
               if (LOAD_LAT > 1) begin
                  state_nxt_s = ST_STALL;
                  cnt_nxt_s   = LAT_M1;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end else if (is_jump(op_d)) begin
               stop_s     = STOP_JMP;
               flush_fd_s = 1'b1;
            end else if (is_branch(op_d)) begin
               stop_s      = STOP_BR;
               flush_fd_s  = 1'b1;
               state_nxt_s = ST_BR_WAIT;
            end else if (op_d == HALT) begin
               stall_fd_s  = 1'b1;
               bubble_de_s = 1'b1;
               state_nxt_s = ST_HALT;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_STALL: begin
            // Decode is frozen here, so op_d is deliberately not looked at
            stop_s      = STOP_HOLD;
            stall_fd_s  = 1'b1;
            bubble_de_s = 1'b1;
            if (cnt_r <= 2'd1) begin
               state_nxt_s = ST_RUN;
               cnt_nxt_s   = 2'd0;
            end else begin
               cnt_nxt_s   = cnt_r - 2'd1;
            end
         end
         ST_BR_WAIT: begin
            // Decode holds the wrong-path slot; squash it and resume
            flush_fd_s  = 1'b1;
            state_nxt_s = ST_RUN;
         end
         ST_HALT: begin
            stall_fd_s  = 1'b1;
            bubble_de_s = 1'b1;
            state_nxt_s = ST_HALT;
         end
         default: begin
            state_nxt_s = ST_RUN;
            cnt_nxt_s   = 2'd0;
         end
      endcase
   end

   // Outputs are forced quiet while reset is held, independent of the clock
   assign stop_d    = rstd ? stop_s      : STOP_RUN;
   assign stall_fd  = rstd ? stall_fd_s  : 1'b0;
   assign flush_fd  = rstd ? flush_fd_s  : 1'b0;
   assign bubble_de = rstd ? bubble_de_s : 1'b0;
   assign halted    = halted_r;
   assign stall_cnt = stall_cnt_r;

   // Sequencer state, stall countdown and halted flag
   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         state_r  <= ST_RUN;
         cnt_r    <= 2'd0;
         halted_r <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         cnt_r    <= cnt_nxt_s;
         halted_r <= (state_nxt_s == ST_HALT);
      end
   end

   // Saturating count of PC-hold cycles for performance debug
   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if ((stop_s == STOP_HOLD) && (stall_cnt_r != {CNT_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: one instance with LOAD_LAT=1, one with
// LOAD_LAT=3 and a 2-bit counter (to reach saturation). Both share stimulus;
// each expectation names which instance it applies to.
module tb_pipe_ctrl;

   logic       clk = 1'b0;
   logic       rstd;
   logic [5:0] op_d, op_e;
   logic [4:0] rs_d, rt_d, rd_e;
   logic       wr_e;

   logic [1:0]  stop1, stop3;
   logic        sfd1, ffd1, bub1, hlt1;
   logic        sfd3, ffd3, bub3, hlt3;
   logic [15:0] cnt1;
   logic [1:0]  cnt3;

   always #5 clk = ~clk;

   pipe_ctrl #(.LOAD_LAT(1), .CNT_W(16)) dut (
      .clk(clk), .rstd(rstd), .op_d(op_d), .rs_d(rs_d), .rt_d(rt_d),
      .op_e(op_e), .rd_e(rd_e), .wr_e(wr_e), .stop_d(stop1),
      .stall_fd(sfd1), .flush_fd(ffd1), .bubble_de(bub1),
      .halted(hlt1), .stall_cnt(cnt1)
   );

   pipe_ctrl #(.LOAD_LAT(3), .CNT_W(2)) dut3 (
      .clk(clk), .rstd(rstd), .op_d(op_d), .rs_d(rs_d), .rt_d(rt_d),
      .op_e(op_e), .rd_e(rd_e), .wr_e(wr_e), .stop_d(stop3),
      .stall_fd(sfd3), .flush_fd(ffd3), .bubble_de(bub3),
      .halted(hlt3), .stall_cnt(cnt3)
   );

   typedef struct packed {
      logic        sel;
      logic [1:0]  stop;
      logic        sfd;
      logic        ffd;
      logic        bub;
      logic        hlt;
      logic [15:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   string       name_q[$];
   int          checks = 0;
   int          errors = 0;
   exp_t        mon_e;
   string       mon_n;
   logic [21:0] mon_got;

   // Drive one cycle of inputs just after the edge and queue its expected response
   task automatic step(input string nm, input int sel, input int rst,
                       input int od, input int rs, input int rt,
                       input int oe, input int rd, input int wr,
                       input int es, input int esfd, input int effd,
                       input int ebub, input int ehlt, input int ecnt);
      exp_t e;
      @(posedge clk);
      #1;
      rstd = 1'(rst);
      op_d = 6'(od); rs_d = 5'(rs); rt_d = 5'(rt);
      op_e = 6'(oe); rd_e = 5'(rd); wr_e = 1'(wr);
      e.sel = 1'(sel); e.stop = 2'(es); e.sfd = 1'(esfd); e.ffd = 1'(effd);
      e.bub = 1'(ebub); e.hlt = 1'(ehlt); e.cnt = 16'(ecnt);
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Monitor: on the falling edge pop one expectation and compare the chosen instance
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         mon_n = name_q.pop_front();
         if (mon_e.sel)
            mon_got = {stop3, sfd3, ffd3, bub3, hlt3, 14'd0, cnt3};
         else
            mon_got = {stop1, sfd1, ffd1, bub1, hlt1, cnt1};
         checks++;
         if (mon_got !== mon_e[21:0]) begin
            errors++;
            $display("FAIL %s: got stop=%b sfd=%b ffd=%b bub=%b halted=%b cnt=%0d, want stop=%b sfd=%b ffd=%b bub=%b halted=%b cnt=%0d",
                     mon_n, mon_got[21:20], mon_got[19], mon_got[18], mon_got[17], mon_got[16], mon_got[15:0],
                     mon_e.stop, mon_e.sfd, mon_e.ffd, mon_e.bub, mon_e.hlt, mon_e.cnt);
         end
      end
   end

   initial begin
      rstd = 1'b0;
      op_d = 6'd0; rs_d = 5'd0; rt_d = 5'd0;
      op_e = 6'd0; rd_e = 5'd0; wr_e = 1'b0;

      //    name                 sel rst  od rs rt  oe rd wr   stop sfd ffd bub hlt cnt
      // Reset gating with a live hazard on the inputs
      step("rst_gate",           0, 0,   0, 5, 0, 16, 5, 1,   0, 0, 0, 0, 0, 0);
      step("rst_gate2",          0, 0,   0, 5, 0, 16, 5, 1,   0, 0, 0, 0, 0, 0);
      // Single-cycle load-use stall (LOAD_LAT=1)
      step("ld_use",             0, 1,   0, 5, 0, 16, 5, 1,   2, 1, 0, 1, 0, 0);
      step("ld_use_cnt",         0, 1,   0, 1, 2,  0, 0, 0,   0, 0, 0, 0, 0, 1);
      step("rd_zero",            0, 1,   0, 0, 0, 16, 0, 1,   0, 0, 0, 0, 0, 1);
      step("rt_hz_store",        0, 1,  24, 1, 7, 16, 7, 1,   2, 1, 0, 1, 0, 1);
      step("rt_unused_load",     0, 1,  16, 1, 7, 16, 7, 1,   0, 0, 0, 0, 0, 2);
      step("wr_off",             0, 1,   0, 5, 0, 16, 5, 0,   0, 0, 0, 0, 0, 2);
      // Jump and branches
      step("jump",               0, 1,  40, 0, 0,  0, 0, 0,   1, 0, 1, 0, 0, 2);
      step("jump_done",          0, 1,   0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 2);
      step("br_issue",           0, 1,  33, 0, 0,  0, 0, 0,   3, 0, 1, 0, 0, 2);
      step("br_wait_ign_j",      0, 1,  40, 0, 0,  0, 0, 0,   0, 0, 1, 0, 0, 2);
      step("br_done",            0, 1,   0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 2);
      step("jr_issue",           0, 1,  42, 0, 0,  0, 0, 0,   3, 0, 1, 0, 0, 2);
      step("jr_wait_ign_halt",   0, 1,  63, 0, 0,  0, 0, 0,   0, 0, 1, 0, 0, 2);
      step("jr_done",            0, 1,   0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 2);
      // Hazard coinciding with a branch: stall first, then 11, 00
      step("hz_br_stall",        0, 1,  32, 5, 0, 16, 5, 1,   2, 1, 0, 1, 0, 2);
      step("hz_br_issue",        0, 1,  32, 5, 0,  0, 0, 0,   3, 0, 1, 0, 0, 3);
      step("hz_br_wait",         0, 1,   0, 0, 0,  0, 0, 0,   0, 0, 1, 0, 0, 3);
      // Hazard coinciding with HALT, then halt held
      step("hz_halt_stall",      0, 1,  63, 5, 0, 16, 5, 1,   2, 1, 0, 1, 0, 3);
      step("halt_detect",        0, 1,  63, 5, 0,  0, 0, 0,   0, 1, 0, 1, 0, 4);
      for (int i = 0; i < 11; i++)
         step("halt_hold",       0, 1,   0, 5, 0, 16, 5, 1,   0, 1, 0, 1, 1, 4);
      step("rst_mid_halt",       0, 0,   0, 5, 0, 16, 5, 1,   0, 0, 0, 0, 0, 0);

      // LOAD_LAT=3 instance with a 2-bit saturating counter
      step("rst_lat3",           1, 0,   0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0);
      step("ml_c1",              1, 1,   0, 5, 0, 16, 5, 1,   2, 1, 0, 1, 0, 0);
      step("ml_c2_ign_j",        1, 1,  40, 5, 0,  0, 0, 0,   2, 1, 0, 1, 0, 1);
      step("ml_c3_ign_br",       1, 1,  33, 5, 0,  0, 0, 0,   2, 1, 0, 1, 0, 2);
      step("ml_done",            1, 1,   0, 1, 2,  0, 0, 0,   0, 0, 0, 0, 0, 3);
      step("ml_jump",            1, 1,  40, 0, 0,  0, 0, 0,   1, 0, 1, 0, 0, 3);
      step("sat_c1",             1, 1,   0, 5, 0, 16, 5, 1,   2, 1, 0, 1, 0, 3);
      step("sat_c2",             1, 1,   0, 0, 0,  0, 0, 0,   2, 1, 0, 1, 0, 3);
      step("sat_c3",             1, 1,   0, 0, 0,  0, 0, 0,   2, 1, 0, 1, 0, 3);
      step("sat_done",           1, 1,   0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 3);

      // Let the monitor drain, with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() > 0; i++)
         @(posedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Hazard and control-flow sequencer for the 5-stage pipeline. Inspects the decode-stage and execute-stage instructions each cycle and generates the `stop_d` command consumed by the program counter, plus hold/flush/bubble controls for the IF/ID and ID/EX pipeline registers. It sequences load-use stalls, absolute jumps, two-cycle branch resolution and program halt, and keeps a saturating stall-cycle counter for performance debug.

## Interface
- `LOAD_LAT`, 1: stall cycles inserted per load-use hazard (1..3).
- `CNT_W`, 16: width of the stall counter.
- `clk` in 1: clock; reset `rstd`, asynchronous, active-low.
- `rstd` in 1: asynchronous active-low reset.
- `op_d` in 6: opcode of the instruction in decode.
- `rs_d` in 5: first source register of the decode instruction.
- `rt_d` in 5: second source register of the decode instruction.
- `op_e` in 6: opcode of the instruction in execute.
- `rd_e` in 5: destination register of the execute instruction.
- `wr_e` in 1: the execute instruction writes `rd_e`.
- `stop_d` out 2: PC command. 00 = run, 01 = jump to absolute address, 10 = hold PC, 11 = branch resolves next cycle.
- `stall_fd` out 1: hold the IF/ID register.
- `flush_fd` out 1: replace the IF/ID contents with NOP.
- `bubble_de` out 1: load NOP into the ID/EX register.
- `halted` out 1: the pipeline has stopped on HALT.
- `stall_cnt` out CNT_W: saturating count of cycles with `stop_d == 10`.

## Operation
- **Opcode classes.**
  - LOAD = 16.
  - BRANCH = 32..35 and JR = 42; both are classed as branch.
  - J = 40, JAL = 41; both are classed as jump.
  - HALT = 63.
  - `uses_rt` is true for opcodes 0 (R-type), 24 (store) and 32..35.
- **Hazard.** `hz = (op_e == LOAD) & wr_e & (rd_e != 0) & (rd_e == rs_d | (uses_rt(op_d) & rd_e == rt_d))`.
- **FSM states:** RUN, STALL, BR_WAIT, HALT.
- **RUN.** Outputs are evaluated in priority order:
  1. `hz`: `stop_d` = 10, `stall_fd` = 1, `bubble_de` = 1. If LOAD_LAT > 1, go to STALL with `cnt` = LOAD_LAT-1; otherwise stay in RUN.
  2. Jump class: `stop_d` = 01, `flush_fd` = 1. Stay in RUN.
  3. Branch class: `stop_d` = 11, `flush_fd` = 1. Go to BR_WAIT.
  4. HALT: `stall_fd` = 1, `bubble_de` = 1. Go to HALT.
  5. Otherwise all outputs are 0.
- **STALL.** `stop_d` = 10, `stall_fd` = 1, `bubble_de` = 1. `cnt` decrements each cycle; go to RUN in the cycle after `cnt` reaches 1. The decode instruction is not re-examined while in STALL.
- **BR_WAIT.** Lasts exactly one cycle.
  - `stop_d` = 00 and `flush_fd` = 1; the PC takes its branch-or-fallthrough value at this edge.
  - `op_d` is ignored, because it is the already-fetched wrong-path slot.
  - Return to RUN.
- **HALT.** Absorbing state: only reset leaves it.
  - `halted` = 1, `stall_fd` = 1, `bubble_de` = 1, `stop_d` = 00.
- **stall_cnt.** Increments on every clock edge where `stop_d == 10`. It saturates at all-ones and does not wrap.
- **Simultaneous events.**
  - A hazard together with a branch or jump in decode resolves as the stall first. The branch or jump is then issued from RUN once the stall clears, because decode still holds it.
  - A hazard together with HALT also resolves as the stall first.

## Timing
- The outputs `stop_d`, `stall_fd`, `flush_fd` and `bubble_de` are combinational from the state and inputs of the same cycle. The PC and pipeline registers act on them at the next rising edge.
- `halted` and `stall_cnt` are registered.
- **Reset.** While `rstd` = 0, every output is forced to 0 (combinational gating) and the state is RUN. Reset asserted mid-STALL or mid-BR_WAIT abandons the sequence immediately.
- **Stall cost.** A load-use hazard costs exactly LOAD_LAT cycles of `stop_d` = 10.
- **Branch cost.** A branch costs 2 cycles: the 11 cycle, then the BR_WAIT cycle. A jump costs 1 cycle.
- **HALT.** Detected in cycle t; `halted` is 1 from cycle t+1.

## Structure
- Shared package `pipe_pkg` holds:
  - the opcode constants LOAD, STORE, J, JAL, JR, BR_EQ..BR_LE, HALT;
  - the `stop_d` encodings STOP_RUN, STOP_JMP, STOP_HOLD, STOP_BR;
  - the FSM state enum.
- Sub-module `hazard_det` is purely combinational and produces `hz` from `op_e`, `wr_e`, `rd_e`, `op_d`, `rs_d` and `rt_d`. It is reused by a later forwarding unit.

## Test plan
- **Load-use stall.** `op_e` = 16, `wr_e` = 1, `rd_e` = 5; `op_d` = 0, `rs_d` = 5. Expect 1 cycle of `stop_d` = 10, `stall_fd` = 1, `bubble_de` = 1, and `stall_cnt` 0→1. Repeat with `rd_e` = 0: no stall.
- **Multi-cycle stall.** LOAD_LAT = 3, same hazard. Expect exactly 3 consecutive cycles of `stop_d` = 10, with `op_d` ignored in cycles 2 and 3; `stall_cnt` = 3.
- **Branch.** `op_d` = 33, no hazard. Expect cycle 1 `stop_d` = 11 with `flush_fd` = 1, then cycle 2 `stop_d` = 00 with `flush_fd` = 1 while `op_d` = 40 is present and ignored; RUN follows.
- **Jump.** `op_d` = 40. Expect a single cycle of `stop_d` = 01 with `flush_fd` = 1.
- **Stall before branch.** Hazard and `op_d` = 32 in the same cycle. Expect `stop_d` sequence 10, 11, 00.
- **Halt and reset.** `op_d` = 63. Expect `halted` = 1 from the next cycle and held for 10+ cycles with `stall_fd` = 1. Pull `rstd` low mid-HALT: all outputs 0 immediately, `stall_cnt` = 0.
